// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial link (transmitter and checker side).
package odd_parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Start, parity and stop bits surround the payload.
  localparam int NON_DATA_BITS = 3;

  function automatic int frame_cycles(input int data_w, input int baud_div);
    return (data_w + NON_DATA_BITS) * baud_div;
  endfunction

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity bit: makes the ones count over data plus this bit odd.
module odd_parity_gen #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter: start, DATA_W bits LSB-first, parity, stop.
// Optional macro ODD_PARITY_TX_ERR_INJECT_EN adds inject_err to force even parity for one frame.
module odd_parity_serial_tx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int BAUD_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ODD_PARITY_TX_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

  tx_state_e         state, state_nxt;
  logic [BW-1:0]     baud_cnt, baud_nxt;
  logic [CW-1:0]     bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              parity, parity_nxt;
  logic              gen_parity;
  logic              serial_nxt, done_nxt;
  logic              baud_wrap, accept, frame_parity;

  odd_parity_gen #(.DATA_W(DATA_W)) u_gen (
    .data   (in_data),
    .parity (gen_parity)
  );

`ifdef ODD_PARITY_TX_ERR_INJECT_EN
  assign frame_parity = gen_parity ^ inject_err;
`else
  assign frame_parity = gen_parity;
`endif

  assign in_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    parity_nxt = parity;
    if (state != IDLE) begin
      baud_nxt = baud_wrap ? '0 : baud_cnt + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = START;
          baud_nxt   = '0;
          bit_nxt    = '0;
          shift_nxt  = in_data;
          parity_nxt = frame_parity;
        end
      end
      START: begin
        if (baud_wrap) state_nxt = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = PARITY;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) state_nxt = STOP;
      end
      STOP: begin
        if (baud_wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level and done pulse are registered from the upcoming state so they
  // line up exactly with the state they describe.
  always_comb begin
    serial_nxt = 1'b1;
    unique case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      PARITY:  serial_nxt = parity_nxt;
      default: serial_nxt = 1'b1;
    endcase
    done_nxt = (state_nxt == STOP) && (baud_nxt == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      tx_serial  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      parity     <= parity_nxt;
      tx_serial  <= serial_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule
